// File: rtl/mvm_sequencer.sv
// mvm_sequencer: row-serial y = W*v + b through one MAC; define SATURATE_EN to clamp overflowed results
module mvm_sequencer #(
  parameter int M = 4,
  parameter int N = 4,
  parameter int NUM_S = 1,
  localparam int AW = (M * N > 1) ? $clog2(M * N) : 1,
  localparam int VW = (N > 1) ? $clog2(N) : 1,
  localparam int BW = (M > 1) ? $clog2(M) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                ready,
  output logic                done,
  output logic                rd_en,
  output logic [AW-1:0]       addr_w,
  output logic [VW-1:0]       addr_v,
  output logic [BW-1:0]       addr_b,
  output logic                mac_valid_in,
  input  logic signed [15:0]  mac_f,
  input  logic                mac_valid_out,
  input  logic                mac_overflow,
  output logic                y_wr_en,
  output logic [BW-1:0]       y_addr,
  output logic [15:0]         y_data,
  output logic [M-1:0]        ovf_flags
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  state_t r_state, w_next;
  logic [BW-1:0] r_row, r_y_addr;
  logic [VW-1:0] r_col;
  logic [AW-1:0] r_base;
  logic [15:0] r_y_data, w_y_data;
  logic [M-1:0] r_ovf;
  logic r_mac_valid_in, r_y_wr_en, w_col_last, w_row_last, w_accept;
  if (M < 1 || N < 1 || NUM_S < 0) begin : g_param_check
    $error("mvm_sequencer: M and N must be >= 1, NUM_S >= 0");
  end
  always_comb begin
    w_col_last = r_col == VW'(N - 1);
    w_row_last = r_row == BW'(M - 1);
    w_accept = r_state == S_WAIT && mac_valid_out;
    w_next = r_state == S_IDLE  ? (start ? S_ISSUE : S_IDLE) :
             r_state == S_ISSUE ? (w_col_last ? S_WAIT : S_ISSUE) :
             r_state == S_WAIT  ? (mac_valid_out ? (w_row_last ? S_DONE : S_ISSUE) : S_WAIT) :
                                  S_IDLE;
`ifdef SATURATE_EN
    // a positive overflow wraps negative, so the wrapped sign picks the opposite rail
    w_y_data = mac_overflow ? (mac_f[15] ? 16'h7FFF : 16'h8000) : mac_f;
`else
    w_y_data = mac_f;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_row <= '0;
      r_col <= '0;
      r_base <= '0;
      r_mac_valid_in <= 1'b0;
      r_y_wr_en <= 1'b0;
      r_y_addr <= '0;
      r_y_data <= '0;
      r_ovf <= '0;
    end else begin
      r_state <= w_next;
      r_mac_valid_in <= r_state == S_ISSUE;
      r_y_wr_en <= w_accept;
      if (r_state == S_IDLE && start) begin
        r_row <= '0;
        r_col <= '0;
        r_base <= '0;
        r_ovf <= '0;
      end
      if (r_state == S_ISSUE) r_col <= w_col_last ? '0 : r_col + 1'b1;
      if (w_accept) begin
        r_y_addr <= r_row;
        r_y_data <= w_y_data;
        r_ovf[r_row] <= mac_overflow;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
        r_base <= w_row_last ? '0 : r_base + AW'(N);
      end
    end
  end
  assign ready = r_state == S_IDLE;
  assign rd_en = r_state == S_ISSUE;
  assign done = r_state == S_DONE;
  assign addr_w = r_base + AW'(r_col);
  assign addr_v = r_col;
  assign addr_b = r_row;
  assign mac_valid_in = r_mac_valid_in;
  assign y_wr_en = r_y_wr_en;
  assign y_addr = r_y_addr;
  assign y_data = r_y_data;
  assign ovf_flags = r_ovf;
endmodule

// File: tb/tb_mvm_sequencer.sv
// tb_mvm_sequencer: two sequencer instances (M2/N3/S1 and M3/N4/S3) driving behavioural MAC and memories
`timescale 1ns/1ps
module tb_mvm_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;
  logic [1:0] st = '0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int w_mem [2][12];
  int v_mem [2][4];
  int b_mem [2][3];
  logic [1:0] rdy, dn, rd, mvi, wr;
  logic [1:0][3:0] aw, av, ab, ya, ovf;
  logic [1:0][15:0] yd;
  function automatic logic [16:0] pack(int s);
    return {s > 32767 || s < -32768, s[15:0]};
  endfunction
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int M = g ? 3 : 2;
    localparam int N = g ? 4 : 3;
    localparam int S = g ? 3 : 1;
    localparam int D = S + 2;
    localparam int AWW = $clog2(M * N);
    localparam int VW = $clog2(N);
    localparam int BW = $clog2(M);
    logic [AWW-1:0] w_aw;
    logic [VW-1:0] w_av;
    logic [BW-1:0] w_ab, w_ya;
    logic [M-1:0] w_ovf;
    logic signed [15:0] mac_f;
    logic mac_vo, mac_ov;
    mvm_sequencer #(.M(M), .N(N), .NUM_S(S)) dut (
      .clk(clk), .reset(reset), .start(st[g]), .ready(rdy[g]), .done(dn[g]),
      .rd_en(rd[g]), .addr_w(w_aw), .addr_v(w_av), .addr_b(w_ab),
      .mac_valid_in(mvi[g]), .mac_f(mac_f), .mac_valid_out(mac_vo),
      .mac_overflow(mac_ov), .y_wr_en(wr[g]), .y_addr(w_ya), .y_data(yd[g]),
      .ovf_flags(w_ovf)
    );
    assign aw[g] = 4'(w_aw);
    assign av[g] = 4'(w_av);
    assign ab[g] = 4'(w_ab);
    assign ya[g] = 4'(w_ya);
    assign ovf[g] = 4'(w_ovf);
    int rw, rv, rb, acc, cnt;
    logic [D-1:0] vp;
    logic [16:0] fp [D];
    always @(posedge clk) begin
      if (rd[g]) begin
        rw <= w_mem[g][w_aw];
        rv <= v_mem[g][w_av];
        rb <= b_mem[g][w_ab];
      end
      if (reset) begin
        acc <= 0;
        cnt <= 0;
        vp <= '0;
      end else begin
        vp <= {vp[D-2:0], mvi[g] && cnt == N - 1};
        fp[0] <= pack(acc + rw * rv + rb);
        for (int i = 1; i < D; i++) fp[i] <= fp[i-1];
        if (mvi[g]) begin
          acc <= cnt == N - 1 ? 0 : acc + rw * rv;
          cnt <= cnt == N - 1 ? 0 : cnt + 1;
        end
      end
    end
    assign mac_vo = vp[D-1];
    assign {mac_ov, mac_f} = fp[D-1];
  end
  int wr_cnt [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int rd_cnt [2] = '{0, 0};
  int lag_err [2] = '{0, 0};
  int done_cyc [2] = '{0, 0};
  logic [15:0] y_log [2][4];
  int wcyc [2][4];
  int aw_log [2][256], av_log [2][256], ab_log [2][256];
  logic rs_q = 1'b1;
  logic [1:0] prev_rd = '0;
  always @(posedge clk) rs_q <= reset;
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (wr[g]) begin
        y_log[g][ya[g]] = yd[g];
        wcyc[g][ya[g]] = cyc;
        wr_cnt[g]++;
      end
      if (dn[g]) begin
        done_cnt[g]++;
        done_cyc[g] = cyc;
      end
      if (rd[g]) begin
        aw_log[g][rd_cnt[g] % 256] = int'(aw[g]);
        av_log[g][rd_cnt[g] % 256] = int'(av[g]);
        ab_log[g][rd_cnt[g] % 256] = int'(ab[g]);
        rd_cnt[g]++;
      end
      if (!rs_q && mvi[g] != prev_rd[g]) lag_err[g]++;
      prev_rd[g] = rd[g];
    end
  end
  typedef struct {
    int g;
    int w [12];
    int v [4];
    int b [3];
    logic [15:0] ey [3];
    logic [3:0] eovf;
  } vec_t;
  vec_t tv [4];
  int vec = 0, bad = 0;
  int t0, bw, bd, br, bl;
  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  function automatic int mrow(int g); return g ? 3 : 2; endfunction
  function automatic int ncol(int g); return g ? 4 : 3; endfunction
  function automatic int lat(int g); return g ? 10 : 7; endfunction
  task automatic go(int k);
    int g = tv[k].g;
    w_mem[g] = tv[k].w;
    v_mem[g] = tv[k].v;
    b_mem[g] = tv[k].b;
    bw = wr_cnt[g];
    bd = done_cnt[g];
    br = rd_cnt[g];
    bl = lag_err[g];
    st[g] = 1'b1;
    t0 = cyc;
    tick;
    st[g] = 1'b0;
    check("ovf_clear_on_start", 32'(ovf[g]), 0);
    check("busy_not_ready", 32'(rdy[g]), 0);
  endtask
  task automatic finish_vec(int k);
    int g = tv[k].g;
    int m = mrow(g), n = ncol(g), l = lat(g);
    for (int i = 0; i < 400 && done_cnt[g] == bd; i++) tick;
    check("done_count", done_cnt[g] - bd, 1);
    check("done_latency", done_cyc[g] - t0, 1 + m * l);
    check("write_count", wr_cnt[g] - bw, m);
    for (int r = 0; r < m; r++) begin
      check("y_data", 32'(y_log[g][r]), 32'(tv[k].ey[r]));
      check("write_cycle", wcyc[g][r] - t0, 1 + (r + 1) * l);
    end
    check("ovf_flags", 32'(ovf[g]), 32'(tv[k].eovf));
    check("rd_count", rd_cnt[g] - br, m * n);
    for (int i = 0; i < m * n; i++) begin
      check("addr_w", aw_log[g][(br + i) % 256], i);
      check("addr_v", av_log[g][(br + i) % 256], i % n);
      check("addr_b", ab_log[g][(br + i) % 256], i / n);
    end
    check("valid_in_lag", lag_err[g] - bl, 0);
    tick;
    check("ready_after_done", 32'(rdy[g]), 1);
    check("done_one_cycle", 32'(dn[g]), 0);
    check("ovf_persists", 32'(ovf[g]), 32'(tv[k].eovf));
  endtask
  initial begin
    tv[0].g = 0;
    tv[0].w = '{1, 2, 3, 4, 5, 6, 0, 0, 0, 0, 0, 0};
    tv[0].v = '{1, 1, 1, 0};
    tv[0].b = '{10, 20, 0};
    tv[0].ey = '{16'd16, 16'd35, 16'd0};
    tv[0].eovf = 4'b0000;
    tv[1].g = 0;
    tv[1].w = '{127, 127, 127, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[1].v = '{127, 127, 127, 0};
    tv[1].b = '{0, 5, 0};
`ifdef SATURATE_EN
    tv[1].ey = '{16'h7FFF, 16'd132, 16'd0};
`else
    tv[1].ey = '{16'hBD03, 16'd132, 16'd0};
`endif
    tv[1].eovf = 4'b0001;
    tv[2].g = 0;
    tv[2].w = '{2, -3, 1, -128, -128, -128, 0, 0, 0, 0, 0, 0};
    tv[2].v = '{127, 127, 127, 0};
    tv[2].b = '{-7, 0, 0};
`ifdef SATURATE_EN
    tv[2].ey = '{16'hFFF9, 16'h8000, 16'd0};
`else
    tv[2].ey = '{16'hFFF9, 16'h4180, 16'd0};
`endif
    tv[2].eovf = 4'b0010;
    tv[3].g = 1;
    tv[3].w = '{1, 2, 3, 4, -1, -2, -3, -4, 0, 5, 0, 5};
    tv[3].v = '{1, 2, 3, 4};
    tv[3].b = '{100, -50, 7};
    tv[3].ey = '{16'd130, 16'hFFB0, 16'd37};
    tv[3].eovf = 4'b0000;
    repeat (3) tick;
    reset = 1'b0;
    tick;
    for (int g = 0; g < 2; g++) begin
      check("rst_ready", 32'(rdy[g]), 1);
      check("rst_done", 32'(dn[g]), 0);
      check("rst_rd_en", 32'(rd[g]), 0);
      check("rst_valid_in", 32'(mvi[g]), 0);
      check("rst_y_wr_en", 32'(wr[g]), 0);
      check("rst_addrs", 32'({aw[g], av[g], ab[g], ya[g]}), 0);
      check("rst_y_data", 32'(yd[g]), 0);
      check("rst_ovf", 32'(ovf[g]), 0);
    end
    for (int k = 0; k < 4; k++) begin
      go(k);
      finish_vec(k);
    end
    // start pulses while busy must be ignored
    go(0);
    tick;
    st[0] = 1'b1;
    check("ready_in_issue", 32'(rdy[0]), 0);
    check("rd_in_issue", 32'(rd[0]), 1);
    tick;
    st[0] = 1'b0;
    while (cyc - t0 < 5) tick;
    st[0] = 1'b1;
    check("ready_in_wait", 32'(rdy[0]), 0);
    check("rd_in_wait", 32'(rd[0]), 0);
    tick;
    st[0] = 1'b0;
    finish_vec(0);
    repeat (20) tick;
    check("no_restart_writes", wr_cnt[0] - bw, 2);
    check("no_restart_done", done_cnt[0] - bd, 1);
    // reset during the second row's issue aborts the product
    go(1);
    while (cyc - t0 < 9) tick;
    check("row1_issuing", 32'({rd[0], ab[0]}), 32'({1'b1, 4'd1}));
    check("row0_ovf_set", 32'(ovf[0]), 1);
    check("row0_written", wr_cnt[0] - bw, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("abort_ready", 32'(rdy[0]), 1);
    check("abort_rd_en", 32'(rd[0]), 0);
    check("abort_ovf", 32'(ovf[0]), 0);
    repeat (30) tick;
    check("abort_no_write", wr_cnt[0] - bw, 1);
    check("abort_no_done", done_cnt[0] - bd, 0);
    go(0);
    finish_vec(0);
    go(3);
    finish_vec(3);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/mvm_sequencer.md
Name: mvm_sequencer

Overview:
- Sequences one matrix-vector product y = W·v + b through a single part3 MAC instance.
- Generates read addresses for the weight, vector and bias memories and drives the MAC valid_in.
- Collects each row result (f, overflow) from the MAC and writes it to the result memory.
- Sits between the top-level start/done control and the MAC/memory datapath.

Parameters:
- M, 4, number of matrix rows (result count), >=1
- N, VEC_S, columns per row; must equal the MAC's VEC_S
- NUM_S, NUM_S, MAC multiplier stages; used only for the latency check in the bench

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a product when ready=1, ignored otherwise
- ready  out  1  high in IDLE
- done  out  1  one-cycle pulse when the last result is written
- rd_en  out  1  read enable to the W/v/b memories; data valid next cycle
- addr_w  out  $clog2(M*N)  weight address, row*N+col
- addr_v  out  $clog2(N)  vector address, col
- addr_b  out  $clog2(M)  bias address, row
- mac_valid_in  out  1  rd_en delayed one cycle (memory latency)
- mac_f  in  16 signed  MAC result
- mac_valid_out  in  1  MAC result valid
- mac_overflow  in  1  MAC overflow, valid with mac_valid_out
- y_wr_en  out  1  result write strobe
- y_addr  out  $clog2(M)  result address (row)
- y_data  out  16  result data
- ovf_flags  out  M  per-row overflow flags; cleared on accepted start

Behaviour:
- Reset: clk and reset are shared with the MAC. Reset puts the FSM in IDLE and clears the row/col counters and ovf_flags. After reset, outputs are:
  - ready=1
  - done=0, rd_en=0, mac_valid_in=0, y_wr_en=0
  - all addresses=0, y_data=0
- Reset mid-operation: abort immediately with no further writes. The MAC is reset by the same signal, so no stale valid_out arrives.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: ready=1. start=1 moves to ISSUE with row=0, col=0, and clears ovf_flags.
- ISSUE: rd_en=1 every cycle and col increments.
  - addr_b is held at row for the whole row. The MAC latches the bias each element, so it must not change within a row.
  - When col==N-1, col returns to 0 and the FSM moves to WAIT.
- WAIT: rd_en=0.
  - On mac_valid_out, register for the next cycle: y_wr_en=1, y_addr=row, y_data=mac_f, and ovf_flags[row]=mac_overflow.
  - If row==M-1, go to DONE; otherwise row++ and go to ISSUE.
- DONE: done=1 for one cycle, coincident with the final y_wr_en, then go to IDLE.
- Rows are issued strictly serially: row r+1 is not issued until row r's valid_out is received. This keeps the MAC bias latch correct for any N and NUM_S.
- mac_valid_out outside WAIT is ignored (protocol error; no write). start outside IDLE is ignored.
- Latency:
  - Last mac_valid_in to mac_valid_out is NUM_S+2 cycles.
  - Each row takes N+NUM_S+3 cycles.
  - A start accepted at cycle 0 gives done at cycle 1+M*(N+NUM_S+3).
- M=1 and N=1 are legal. Counters wrap to 0 at their final value.
- ovf_flags persist after done until the next accepted start or reset.

Optional Feature:
- Macro SATURATE_EN.
- Defined: when mac_overflow=1 with mac_valid_out, y_data is clamped.
  - mac_f[15]=1 (positive overflow wrapped negative) gives y_data=16'h7FFF.
  - mac_f[15]=0 gives y_data=16'h8000.
  - ovf_flags is still set.
- Not defined: y_data=mac_f unmodified and ovf_flags is still set.

Test Plan:
- Basic product, M=2, N=3, NUM_S=1. W={{1,2,3},{4,5,6}}, v={1,1,1}, b={10,20}, start at cycle 0:
  - y[0]=16 and y[1]=35.
  - y_wr_en at cycles 8 and 15.
  - done at cycle 15.
  - ovf_flags=2'b00.
- Address sequence for the same run: addr_w 0,1,2 then 3,4,5; addr_v 0,1,2 twice; addr_b constant 0 then 1.
  - rd_en high for exactly 3 cycles per row.
  - mac_valid_in lags rd_en by 1 cycle.
- Overflow, row W={127,127,127}, v={127,127,127}, b=0:
  - Without SATURATE_EN: y=16'hBD03 and ovf_flags[0]=1.
  - With SATURATE_EN: y=16'h7FFF and ovf_flags[0]=1.
  - A second start clears ovf_flags to 0.
- start pulsed during ISSUE and during WAIT: ignored. Exactly M writes and one done; ready=0 until after done.
- reset asserted during the second row's ISSUE: the next cycle shows ready=1, rd_en=0, ovf_flags=0, and no y_wr_en or done follows. A new start then completes normally with correct results.
- NUM_S=3, N=4, M=3: done exactly 1+3*(4+3+3)=31 cycles after start, with all results correct.
